ip_tx_arbiter: RTL and testbench

- Shares the single IP/Ethernet frame sender between two payload requesters, e.g. UDP and ICMP.
- Round-robin arbitration between the requesters.
- Latches the winner's header fields and holds them stable for the whole frame.
- Streams the winner's payload into the sender with a len-cycle start strobe, then waits for the sender's busy cycle to finish before re-arbitrating.

---
 rtl/ip_tx_pkg.sv | 28 ++
 rtl/rr_arb2.sv | 37 +++
 rtl/ip_tx_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_ip_tx_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_tx_pkg.sv
// ============================================================================
// Module  : ip_tx_pkg
// Purpose : Shared state encoding and constants for the IP TX arbiter slice.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package ip_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_STREAM  = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_WAIT_LO = 3'd4,
        ST_ABORT   = 3'd5
    } state_e;

    localparam int DEF_MAX_LEN      = 1472;
    localparam int DEF_BUSY_TIMEOUT = 4095;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  PROTO_UDP      = 8'd17;
    localparam logic [7:0]  PROTO_ICMP     = 8'd1;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module  : rr_arb2
// Purpose : Two-way round-robin arbiter; pointer moves only on update strobe.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    input  logic       served_i,
    output logic [1:0] gnt_o
);

    // Index of the requester served last; reset value 1 makes requester 0 win ties.
    logic last_q;

    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
        end else if (upd_i) begin
            last_q <= served_i;
        end
    end

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ip_tx_arbiter.sv
// ============================================================================
// Module  : ip_tx_arbiter
// Purpose : Shares one IP/Ethernet frame sender between two payload requesters.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module ip_tx_arbiter
    import ip_tx_pkg::*;
#(
    parameter int MAX_LEN      = DEF_MAX_LEN,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [47:0] src_mac_i,
    input  logic [31:0] src_ip_i,
    input  logic        req0_i,
    input  logic [15:0] len0_i,
    input  logic [7:0]  type0_i,
    input  logic [47:0] dst_mac0_i,
    input  logic [31:0] dst_ip0_i,
    input  logic [7:0]  data0_i,
    input  logic        req1_i,
    input  logic [15:0] len1_i,
    input  logic [7:0]  type1_i,
    input  logic [47:0] dst_mac1_i,
    input  logic [31:0] dst_ip1_i,
    input  logic [7:0]  data1_i,
    output logic        rd0_o,
    output logic        gnt0_o,
    output logic        done0_o,
    output logic        err0_o,
    output logic        rd1_o,
    output logic        gnt1_o,
    output logic        done1_o,
    output logic        err1_o,
    output logic [47:0] ip_src_mac_o,
    output logic [47:0] ip_dst_mac_o,
    output logic [31:0] ip_src_ip_o,
    output logic [31:0] ip_dst_ip_o,
    output logic [7:0]  ip_data_type_o,
    output logic [15:0] ip_len_o,
    output logic [7:0]  ip_data_o,
    output logic        ip_start_o,
    input  logic        ip_busy_i
);

    localparam int          TW        = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
    localparam logic [TW-1:0] TMO_W   = TW'(BUSY_TIMEOUT);

    state_e        state_q, state_d;
    logic          sel_q, sel_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    done_q, done_d;
    logic [1:0]    err_q, err_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ip_start_q, ip_start_d;
    logic [7:0]    ip_data_q, ip_data_d;
    logic [47:0]   ip_src_mac_q, ip_dst_mac_q;
    logic [31:0]   ip_src_ip_q, ip_dst_ip_q;
    logic [7:0]    ip_type_q;
    logic [15:0]   ip_len_q;

    logic [1:0]    w_arb_gnt;
    logic          w_hdr_load;
    logic          w_upd;
    logic          w_can_arb;
    logic [1:0]    w_sel_oh;
    logic [TW-1:0] w_tmo_inc;

    rr_arb2 u_rr_arb2 (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    ({req1_i, req0_i}),
        .upd_i    (w_upd),
        .served_i (sel_q),
        .gnt_o    (w_arb_gnt)
    );

    // The done/err pulse cycle is skipped so a requester can drop req on seeing it.
    assign w_can_arb = !ip_busy_i && (done_q == 2'b00) && (err_q == 2'b00)
                       && (req0_i || req1_i);
    assign w_sel_oh  = sel_q ? 2'b10 : 2'b01;
    assign w_tmo_inc = tmo_q + TW'(1);

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        gnt_d      = gnt_q;
        done_d     = 2'b00;
        err_d      = 2'b00;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        ip_start_d = 1'b0;
        ip_data_d  = ip_data_q;
        w_hdr_load = 1'b0;
        w_upd      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_can_arb) begin
                    sel_d      = w_arb_gnt[1];
                    gnt_d      = w_arb_gnt;
                    w_hdr_load = 1'b1;
                    cnt_d      = w_arb_gnt[1] ? len1_i : len0_i;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if ((ip_len_q == 16'd0) || (ip_len_q > MAX_LEN_W)) begin
                    err_d   = w_sel_oh;
                    gnt_d   = 2'b00;
                    w_upd   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                ip_start_d = 1'b1;
                ip_data_d  = sel_q ? data1_i : data0_i;
                cnt_d      = cnt_q - 16'd1;
                if (cnt_q == 16'd1) begin
                    tmo_d   = '0;
                    state_d = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (ip_busy_i) begin
                    tmo_d   = '0;
                    state_d = ST_WAIT_LO;
                end else if (w_tmo_inc == TMO_W) begin
                    state_d = ST_ABORT;
                end else begin
                    tmo_d = w_tmo_inc;
                end
            end
            ST_WAIT_LO: begin
                if (!ip_busy_i) begin
                    done_d  = w_sel_oh;
                    gnt_d   = 2'b00;
                    w_upd   = 1'b1;
                    state_d = ST_IDLE;
                end else if (w_tmo_inc == TMO_W) begin
                    state_d = ST_ABORT;
                end else begin
                    tmo_d = w_tmo_inc;
                end
            end
            ST_ABORT: begin
                err_d   = w_sel_oh;
                gnt_d   = 2'b00;
                w_upd   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            sel_q      <= 1'b0;
            gnt_q      <= 2'b00;
            done_q     <= 2'b00;
            err_q      <= 2'b00;
            cnt_q      <= 16'd0;
            tmo_q      <= '0;
            ip_start_q <= 1'b0;
            ip_data_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            ip_start_q <= ip_start_d;
            ip_data_q  <= ip_data_d;
        end
    end

    // Header fields are read live by the sender, so they only move on a new grant.
    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ip_src_mac_q <= 48'd0;
            ip_dst_mac_q <= 48'd0;
            ip_src_ip_q  <= 32'd0;
            ip_dst_ip_q  <= 32'd0;
            ip_type_q    <= 8'd0;
            ip_len_q     <= 16'd0;
        end else if (w_hdr_load) begin
            ip_src_mac_q <= src_mac_i;
            ip_src_ip_q  <= src_ip_i;
            ip_dst_mac_q <= w_arb_gnt[1] ? dst_mac1_i : dst_mac0_i;
            ip_dst_ip_q  <= w_arb_gnt[1] ? dst_ip1_i  : dst_ip0_i;
            ip_type_q    <= w_arb_gnt[1] ? type1_i    : type0_i;
            ip_len_q     <= w_arb_gnt[1] ? len1_i     : len0_i;
        end
    end

    assign rd0_o          = (state_q == ST_STREAM) && !sel_q;
    assign rd1_o          = (state_q == ST_STREAM) &&  sel_q;
    assign gnt0_o         = gnt_q[0];
    assign gnt1_o         = gnt_q[1];
    assign done0_o        = done_q[0];
    assign done1_o        = done_q[1];
    assign err0_o         = err_q[0];
    assign err1_o         = err_q[1];
    assign ip_src_mac_o   = ip_src_mac_q;
    assign ip_dst_mac_o   = ip_dst_mac_q;
    assign ip_src_ip_o    = ip_src_ip_q;
    assign ip_dst_ip_o    = ip_dst_ip_q;
    assign ip_data_type_o = ip_type_q;
    assign ip_len_o       = ip_len_q;
    assign ip_data_o      = ip_data_q;
    assign ip_start_o     = ip_start_q;

endmodule

`default_nettype wire

// File: tb/tb_ip_tx_arbiter.sv
// ============================================================================
// Module  : tb_ip_tx_arbiter
// Purpose : Directed self-checking bench for ip_tx_arbiter.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_ip_tx_arbiter;
    import ip_tx_pkg::*;

    localparam int MAX_LEN      = 1472;
    localparam int BUSY_TIMEOUT = 4095;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [47:0] src_mac = 48'h02_00_00_00_00_01;
    logic [31:0] src_ip  = 32'hC0A8_0001;
    logic        req0, req1;
    logic [15:0] len0, len1;
    logic [7:0]  type0 = PROTO_UDP;
    logic [7:0]  type1 = PROTO_ICMP;
    logic [47:0] dst_mac0 = 48'h02_00_00_00_00_A0;
    logic [47:0] dst_mac1 = 48'h02_00_00_00_00_B1;
    logic [31:0] dst_ip0 = 32'h0A00_0001;
    logic [31:0] dst_ip1 = 32'h0A00_0002;
    logic [7:0]  data0, data1;
    logic [7:0]  base0, base1;
    logic [15:0] idx0, idx1;
    logic        rd0, gnt0, done0, err0, rd1, gnt1, done1, err1;
    logic [47:0] ip_src_mac, ip_dst_mac;
    logic [31:0] ip_src_ip, ip_dst_ip;
    logic [7:0]  ip_data_type, ip_data;
    logic [15:0] ip_len;
    logic        ip_start, ip_busy;

    always #5 clk = ~clk;

    ip_tx_arbiter #(.MAX_LEN(MAX_LEN), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
        .clk_i(clk), .rst_ni(rst_n), .src_mac_i(src_mac), .src_ip_i(src_ip),
        .req0_i(req0), .len0_i(len0), .type0_i(type0), .dst_mac0_i(dst_mac0),
        .dst_ip0_i(dst_ip0), .data0_i(data0),
        .req1_i(req1), .len1_i(len1), .type1_i(type1), .dst_mac1_i(dst_mac1),
        .dst_ip1_i(dst_ip1), .data1_i(data1),
        .rd0_o(rd0), .gnt0_o(gnt0), .done0_o(done0), .err0_o(err0),
        .rd1_o(rd1), .gnt1_o(gnt1), .done1_o(done1), .err1_o(err1),
        .ip_src_mac_o(ip_src_mac), .ip_dst_mac_o(ip_dst_mac),
        .ip_src_ip_o(ip_src_ip), .ip_dst_ip_o(ip_dst_ip),
        .ip_data_type_o(ip_data_type), .ip_len_o(ip_len), .ip_data_o(ip_data),
        .ip_start_o(ip_start), .ip_busy_i(ip_busy)
    );

    // Show-ahead requester FIFOs: byte k of a frame is base + k, popped on the DUT edge.
    assign data0 = base0 + idx0[7:0];
    assign data1 = base1 + idx1[7:0];

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n)     idx0 <= 16'd0;
        else if (!req0) idx0 <= 16'd0;
        else if (rd0)   idx0 <= idx0 + 16'd1;
    end

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n)     idx1 <= 16'd0;
        else if (!req1) idx1 <= 16'd0;
        else if (rd1)   idx1 <= idx1 + 16'd1;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    int          f_who, f_starts, f_rise, f_rd0, f_rd1;
    int          f_done0, f_done1, f_err0, f_err1, f_hdr_bad;
    int          f_last, f_end, f_timeout;
    logic [31:0] f_dst_ip;
    logic [15:0] f_len;
    logic [7:0]  f_bytes[$];

    // Observes one frame at posedges until a done/err pulse; optionally models the sender.
    task automatic run_frame(input bit stuck, input int max_cyc);
        int          busy_left;
        bit          prev_start;
        bit          seen;
        logic [47:0] hdr_mac;
        busy_left = 0; prev_start = 0; seen = 0; hdr_mac = '0;
        f_who = -1; f_starts = 0; f_rise = 0; f_rd0 = 0; f_rd1 = 0;
        f_done0 = 0; f_done1 = 0; f_err0 = 0; f_err1 = 0; f_hdr_bad = 0;
        f_last = -1; f_end = -1; f_timeout = 0; f_dst_ip = '0; f_len = '0;
        f_bytes.delete();
        for (int c = 0; c < max_cyc; c++) begin
            @(posedge clk);
            if ((gnt0 || gnt1) && !seen) begin
                seen = 1; f_who = gnt1 ? 1 : 0;
                f_dst_ip = ip_dst_ip; f_len = ip_len; hdr_mac = ip_dst_mac;
            end else if ((gnt0 || gnt1) &&
                         (ip_dst_ip !== f_dst_ip || ip_dst_mac !== hdr_mac || ip_len !== f_len)) begin
                f_hdr_bad++;
            end
            if (ip_start) begin
                f_bytes.push_back(ip_data);
                f_starts++;
                f_last = c;
                if (!prev_start) f_rise++;
            end
            if (rd0) f_rd0++;
            if (rd1) f_rd1++;
            if (done0) f_done0++;
            if (done1) f_done1++;
            if (err0) f_err0++;
            if (err1) f_err1++;
            if (!stuck) begin
                if (prev_start && !ip_start) busy_left = 3;
                if (busy_left > 0) begin
                    ip_busy = 1'b1;
                    busy_left--;
                end else begin
                    ip_busy = 1'b0;
                end
            end
            prev_start = ip_start;
            if (done0 || done1 || err0 || err1) begin
                f_end = c;
                return;
            end
        end
        f_timeout = 1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ip_busy = 1'b0; req0 = 1'b0; req1 = 1'b0;
        len0 = 16'd0; len1 = 16'd0; base0 = 8'd0; base1 = 8'd0;
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_bytes(input string tag, input logic [7:0] base, input int n);
        int bad;
        bad = 0;
        if (f_bytes.size() != n) bad++;
        for (int i = 0; i < f_bytes.size() && i < n; i++) begin
            if (f_bytes[i] !== 8'(base + 8'(i))) bad++;
        end
        check_val(tag, 64'(bad), 64'd0);
    endtask

    initial begin
        int nst;
        int hold_gnt;
        logic [3:0] seq;

        // Reset state
        rst_n = 1'b0; ip_busy = 1'b0; req0 = 1'b0; req1 = 1'b0;
        len0 = 16'd0; len1 = 16'd0; base0 = 8'd0; base1 = 8'd0;
        #12;
        check_val("rst_ctrl", {55'd0, gnt0, gnt1, rd0, rd1, done0, done1, err0, err1, ip_start}, 64'd0);
        check_val("rst_hdr_mac", {ip_src_mac, ip_len}, 64'd0);
        check_val("rst_hdr_ip", {ip_dst_ip, ip_data_type, ip_data, ip_len}, 64'd0);
        do_reset();

        // Single frame, four bytes A1..A4
        len0 = 16'd4; base0 = 8'hA1; req0 = 1'b1;
        run_frame(1'b0, 100);
        req0 = 1'b0;
        check_val("s_timeout", 64'(f_timeout), 64'd0);
        check_val("s_who", 64'(f_who), 64'd0);
        check_val("s_len", 64'(f_len), 64'd4);
        check_val("s_dstip", 64'(f_dst_ip), 64'(dst_ip0));
        check_val("s_starts", 64'(f_starts), 64'd4);
        check_val("s_rise", 64'(f_rise), 64'd1);
        check_bytes("s_bytes", 8'hA1, 4);
        check_val("s_rd", {32'(f_rd0), 32'(f_rd1)}, {32'd4, 32'd0});
        check_val("s_done", {16'(f_done0), 16'(f_done1), 16'(f_err0), 16'(f_err1)}, {16'd1, 48'd0});
        check_val("s_hdr_type", 64'(ip_data_type), 64'(PROTO_UDP));

        // Both requesting continuously: grants alternate starting at requester 0
        do_reset();
        len0 = 16'd2; len1 = 16'd2; base0 = 8'h10; base1 = 8'h20;
        req0 = 1'b1; req1 = 1'b1;
        seq = 4'd0;
        for (int k = 0; k < 4; k++) begin
            run_frame(1'b0, 100);
            seq[k] = (f_who == 1);
            check_val("alt_dstip", 64'(f_dst_ip), (f_who == 1) ? 64'(dst_ip1) : 64'(dst_ip0));
            check_val("alt_starts_hdr", {32'(f_starts), 32'(f_hdr_bad)}, {32'd2, 32'd0});
        end
        req0 = 1'b0; req1 = 1'b0;
        check_val("alt_seq", 64'(seq), 64'b1010);

        // Zero length on requester 1
        len1 = 16'd0; req1 = 1'b1;
        run_frame(1'b0, 100);
        req1 = 1'b0;
        check_val("zero_err", {16'(f_err0), 16'(f_err1), 16'(f_done0), 16'(f_done1)}, {16'd0, 16'd1, 32'd0});
        check_val("zero_starts", 64'(f_starts), 64'd0);

        // Oversize on requester 0
        len0 = 16'(MAX_LEN + 1); req0 = 1'b1;
        run_frame(1'b0, 100);
        req0 = 1'b0;
        check_val("over_err", {16'(f_err0), 16'(f_err1), 16'(f_done0), 16'(f_done1)}, {16'd1, 48'd0});
        check_val("over_starts", 64'(f_starts), 64'd0);

        // Length boundaries: MAX_LEN and 1 are both legal
        len0 = 16'(MAX_LEN); base0 = 8'h00; req0 = 1'b1;
        run_frame(1'b0, 2000);
        req0 = 1'b0;
        check_val("max_done", 64'(f_done0), 64'd1);
        check_val("max_starts", {32'(f_starts), 32'(f_rise)}, {32'(MAX_LEN), 32'd1});
        check_bytes("max_bytes", 8'h00, MAX_LEN);
        len1 = 16'd1; base1 = 8'h5A; req1 = 1'b1;
        run_frame(1'b0, 100);
        req1 = 1'b0;
        check_val("one_starts", {32'(f_starts), 32'(f_done1)}, {32'd1, 32'd1});
        check_bytes("one_bytes", 8'h5A, 1);

        // Stuck sender: busy never rises. The last start cycle is sampled one posedge
        // before entering WAIT_HI's first edge; BUSY_TIMEOUT WAIT_HI edges, one ABORT
        // edge, then err is visible at the following posedge.
        len0 = 16'd2; base0 = 8'h40; req0 = 1'b1;
        run_frame(1'b1, 6000);
        req0 = 1'b0;
        check_val("stuck_err", {16'(f_err0), 16'(f_done0), 16'(f_timeout), 16'(f_starts)}, {16'd1, 16'd0, 16'd0, 16'd2});
        check_val("stuck_delay", 64'(f_end - f_last), 64'(BUSY_TIMEOUT + 1));

        // Busy held high in IDLE blocks any new grant
        ip_busy = 1'b1; len1 = 16'd3; base1 = 8'h70; req1 = 1'b1;
        hold_gnt = 0;
        repeat (20) begin
            @(posedge clk);
            if (gnt0 || gnt1) hold_gnt++;
        end
        check_val("busy_block", 64'(hold_gnt), 64'd0);
        ip_busy = 1'b0;
        run_frame(1'b0, 100);
        req1 = 1'b0;
        check_val("busy_release", {16'(f_who), 16'(f_starts), 16'(f_done1), 16'(f_timeout)}, {16'd1, 16'd3, 16'd1, 16'd0});
        check_bytes("busy_bytes", 8'h70, 3);

        // Reset mid-frame: requester 0 served once, so the pointer favours 1 before reset
        do_reset();
        len0 = 16'd2; base0 = 8'h00; req0 = 1'b1;
        run_frame(1'b0, 100);
        req0 = 1'b0;
        @(posedge clk);
        len0 = 16'd10; base0 = 8'h30; req0 = 1'b1;
        nst = 0;
        for (int c = 0; c < 50 && nst < 3; c++) begin
            @(posedge clk);
            if (ip_start) nst++;
        end
        check_val("mid_reach", 64'(nst), 64'd3);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_ctrl", {56'd0, gnt0, gnt1, rd0, rd1, done0, done1, err0, ip_start}, 64'd0);
        check_val("mid_rst_hdr", {ip_dst_ip, ip_len, ip_data, ip_data_type}, 64'd0);
        len1 = 16'd5; base1 = 8'h90; req1 = 1'b1;
        @(posedge clk);
        rst_n = 1'b1;
        run_frame(1'b0, 100);
        req0 = 1'b0;
        check_val("mid_who", 64'(f_who), 64'd0);
        check_val("mid_frame", {16'(f_starts), 16'(f_rd0), 16'(f_done0), 16'(f_timeout)}, {16'd10, 16'd10, 16'd1, 16'd0});
        check_bytes("mid_bytes", 8'h30, 10);
        run_frame(1'b0, 100);
        req1 = 1'b0;
        check_val("mid_next", {16'(f_who), 16'(f_starts), 16'(f_done1), 16'(f_timeout)}, {16'd1, 16'd5, 16'd1, 16'd0});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
